// File: rtl/swc_pck_transfer_input.sv
// Per-input-port page transfer stage: holds one packet descriptor and offers it to the
// output ports until every destination has read it, then acknowledges the input block.
module swc_pck_transfer_input #(
  parameter int g_num_ports       = 11,
  parameter int g_page_addr_width = 10,
  parameter int g_prio_width      = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         ib_transfer_pck_i,
  input  logic [g_page_addr_width-1:0] ib_pageaddr_i,
  input  logic [g_num_ports-1:0]       ib_mask_i,
  input  logic [g_prio_width-1:0]      ib_prio_i,
  output logic                         ib_transfer_ack_o,
  output logic                         pto_transfer_pck_o,
  output logic [g_page_addr_width-1:0] pto_pageaddr_o,
  output logic [g_num_ports-1:0]       pto_output_mask_o,
  input  logic [g_num_ports-1:0]       pto_read_mask_i,
  output logic [g_prio_width-1:0]      pto_prio_o
);

  typedef enum logic {
    IDLE,
    TRANSFER
  } state_t;

  state_t state_q, state_d;

  logic                         ack_d;
  logic                         pck_d;
  logic [g_page_addr_width-1:0] pageaddr_d;
  logic [g_num_ports-1:0]       mask_d;
  logic [g_prio_width-1:0]      prio_d;
  logic [g_num_ports-1:0]       remaining_next;

  logic accept_empty;
  logic accept_valid;

  assign accept_empty   = ib_transfer_pck_i && (ib_mask_i == '0);
  assign accept_valid   = ib_transfer_pck_i && (ib_mask_i != '0);
  assign remaining_next = pto_output_mask_o & ~pto_read_mask_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept_valid) state_d = TRANSFER;
      TRANSFER: if (remaining_next == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; read bits outside the remaining set are
  // masked off naturally by the AND with the current remaining mask.
  always_comb begin
    ack_d      = 1'b0;
    pck_d      = 1'b0;
    pageaddr_d = pto_pageaddr_o;
    mask_d     = '0;
    prio_d     = pto_prio_o;
    case (state_q)
      IDLE: begin
        if (ib_transfer_pck_i) begin
          pageaddr_d = ib_pageaddr_i;
          prio_d     = ib_prio_i;
        end
        if (accept_valid) begin
          pck_d  = 1'b1;
          mask_d = ib_mask_i;
        end
        ack_d = accept_empty;
      end
      TRANSFER: begin
        if (remaining_next == '0) begin
          ack_d = 1'b1;
        end else begin
          pck_d  = 1'b1;
          mask_d = remaining_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ib_transfer_ack_o  <= 1'b0;
      pto_transfer_pck_o <= 1'b0;
      pto_pageaddr_o     <= '0;
      pto_output_mask_o  <= '0;
      pto_prio_o         <= '0;
    end else begin
      ib_transfer_ack_o  <= ack_d;
      pto_transfer_pck_o <= pck_d;
      pto_pageaddr_o     <= pageaddr_d;
      pto_output_mask_o  <= mask_d;
      pto_prio_o         <= prio_d;
    end
  end

endmodule

// File: tb/tb_swc_pck_transfer_input.sv
// Directed self-checking bench for swc_pck_transfer_input.
module tb_swc_pck_transfer_input;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ib_transfer_pck_i = 1'b0;
  logic [9:0]  ib_pageaddr_i = '0;
  logic [10:0] ib_mask_i = '0;
  logic [2:0]  ib_prio_i = '0;
  logic        ib_transfer_ack_o;
  logic        pto_transfer_pck_o;
  logic [9:0]  pto_pageaddr_o;
  logic [10:0] pto_output_mask_o;
  logic [10:0] pto_read_mask_i = '0;
  logic [2:0]  pto_prio_o;

  int tests = 0;
  int fails = 0;

  swc_pck_transfer_input #(
    .g_num_ports(11),
    .g_page_addr_width(10),
    .g_prio_width(3)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .ib_transfer_pck_i(ib_transfer_pck_i),
    .ib_pageaddr_i(ib_pageaddr_i),
    .ib_mask_i(ib_mask_i),
    .ib_prio_i(ib_prio_i),
    .ib_transfer_ack_o(ib_transfer_ack_o),
    .pto_transfer_pck_o(pto_transfer_pck_o),
    .pto_pageaddr_o(pto_pageaddr_o),
    .pto_output_mask_o(pto_output_mask_o),
    .pto_read_mask_i(pto_read_mask_i),
    .pto_prio_o(pto_prio_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [9:0] addr, input logic [10:0] mask, input logic [2:0] prio);
    ib_transfer_pck_i = 1'b1;
    ib_pageaddr_i     = addr;
    ib_mask_i         = mask;
    ib_prio_i         = prio;
  endtask

  task automatic idle_inputs();
    ib_transfer_pck_i = 1'b0;
    pto_read_mask_i   = '0;
  endtask

  initial begin
    // reset held
    #12;
    check("rst_ack", ib_transfer_ack_o, 0);
    check("rst_pck", pto_transfer_pck_o, 0);
    check("rst_addr", pto_pageaddr_o, 0);
    check("rst_mask", pto_output_mask_o, 0);
    check("rst_prio", pto_prio_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_ack", ib_transfer_ack_o, 0);
      check("idle_pck", pto_transfer_pck_o, 0);
      check("idle_mask", pto_output_mask_o, 0);
    end

    // accept descriptor
    strobe(10'd123, 11'h005, 3'd2);
    step();
    idle_inputs();
    check("acc_pck", pto_transfer_pck_o, 1);
    check("acc_addr", pto_pageaddr_o, 123);
    check("acc_mask", pto_output_mask_o, 11'h005);
    check("acc_prio", pto_prio_o, 2);
    check("acc_ack", ib_transfer_ack_o, 0);

    // read from a non-destination port
    pto_read_mask_i = 11'h002;
    step();
    idle_inputs();
    check("nondst_mask", pto_output_mask_o, 11'h005);
    check("nondst_pck", pto_transfer_pck_o, 1);
    check("nondst_ack", ib_transfer_ack_o, 0);

    // partial then final read
    pto_read_mask_i = 11'h004;
    step();
    check("part_mask", pto_output_mask_o, 11'h001);
    check("part_pck", pto_transfer_pck_o, 1);
    check("part_ack", ib_transfer_ack_o, 0);
    pto_read_mask_i = 11'h001;
    step();
    idle_inputs();
    check("done_pck", pto_transfer_pck_o, 0);
    check("done_mask", pto_output_mask_o, 0);
    check("done_ack", ib_transfer_ack_o, 1);
    check("done_addr", pto_pageaddr_o, 123);
    check("done_prio", pto_prio_o, 2);
    step();
    check("done_ack_clr", ib_transfer_ack_o, 0);
    check("done_addr_hold", pto_pageaddr_o, 123);

    // all ports at once
    strobe(10'h3FF, 11'h7FF, 3'd7);
    step();
    idle_inputs();
    check("all_mask", pto_output_mask_o, 11'h7FF);
    check("all_prio", pto_prio_o, 7);
    pto_read_mask_i = 11'h7FF;
    step();
    idle_inputs();
    check("all_ack", ib_transfer_ack_o, 1);
    check("all_pck", pto_transfer_pck_o, 0);
    step();
    check("all_ack_once", ib_transfer_ack_o, 0);

    // empty mask: immediate ack
    strobe(10'd55, 11'h000, 3'd1);
    step();
    idle_inputs();
    check("empty_ack", ib_transfer_ack_o, 1);
    check("empty_pck", pto_transfer_pck_o, 0);
    check("empty_addr", pto_pageaddr_o, 55);
    check("empty_prio", pto_prio_o, 1);
    step();
    check("empty_ack_clr", ib_transfer_ack_o, 0);
    check("empty_pck_stay", pto_transfer_pck_o, 0);

    // strobe coincident with ack cycle is accepted
    strobe(10'd10, 11'h001, 3'd0);
    step();
    idle_inputs();
    pto_read_mask_i = 11'h001;
    step();
    idle_inputs();
    check("coin_ack", ib_transfer_ack_o, 1);
    strobe(10'd11, 11'h002, 3'd3);
    step();
    idle_inputs();
    check("coin_pck", pto_transfer_pck_o, 1);
    check("coin_addr", pto_pageaddr_o, 11);
    check("coin_mask", pto_output_mask_o, 11'h002);
    check("coin_ack_clr", ib_transfer_ack_o, 0);
    pto_read_mask_i = 11'h002;
    step();
    idle_inputs();
    check("coin_done", ib_transfer_ack_o, 1);
    step();

    // read mask ignored in idle
    pto_read_mask_i = 11'h7FF;
    step();
    idle_inputs();
    check("idle_read_ack", ib_transfer_ack_o, 0);
    check("idle_read_mask", pto_output_mask_o, 0);

    // second strobe during transfer ignored
    strobe(10'd200, 11'h003, 3'd4);
    step();
    strobe(10'd300, 11'h001, 3'd5);
    step();
    idle_inputs();
    check("ign_addr", pto_pageaddr_o, 200);
    check("ign_mask", pto_output_mask_o, 11'h003);
    check("ign_prio", pto_prio_o, 4);
    check("ign_ack", ib_transfer_ack_o, 0);
    pto_read_mask_i = 11'h001;
    step();
    idle_inputs();
    check("ign_part", pto_output_mask_o, 11'h002);

    // asynchronous reset mid-transfer
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_pck", pto_transfer_pck_o, 0);
    check("arst_mask", pto_output_mask_o, 0);
    check("arst_addr", pto_pageaddr_o, 0);
    check("arst_ack", ib_transfer_ack_o, 0);
    step();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    pto_read_mask_i = 11'h002;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_ack", ib_transfer_ack_o, 0);
      check("post_rst_pck", pto_transfer_pck_o, 0);
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
